// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU among NUM_REQ requesters
module alu_arbiter #(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_REQ       = 4,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [3*NUM_REQ-1:0]          req_op,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_a,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_div_zero,
    output logic                          busy,
    output logic [2:0]                    alu_op,
    output logic [DATA_WIDTH-1:0]         alu_a,
    output logic [DATA_WIDTH-1:0]         alu_b,
    input  logic [DATA_WIDTH-1:0]         alu_f
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   grant_idx;
    logic            grant_found;
    logic [CW-1:0]   hold_cnt;
    logic [2:0]      sel_op;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic            sel_long;
    logic            accept;
    logic            capture;

    // Round-robin pick: first requester after last_grant, wrapping modulo NUM_REQ
    always_comb begin
        int idx;
        idx         = 0;
        grant_idx   = last_grant;
        grant_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && req_valid[GW'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = GW'(idx);
            end
        end
    end

    // Operand mux for the candidate; mul and non-zero div need the long hold window
    always_comb begin
        sel_op   = req_op[int'(grant_idx)*3 +: 3];
        sel_a    = req_a[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        sel_b    = req_b[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        sel_long = (sel_op == OP_MUL) || ((sel_op == OP_DIV) && (sel_b != '0));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, hold ALU inputs until the counter expires, respond once
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        capture = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_found) begin
                    accept  = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC, S_WAIT: begin
                if (hold_cnt == '0) begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // One-hot strobes; accept is masked during reset since state already reads IDLE then
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        busy      = (state != S_IDLE);
        if ((state == S_IDLE) && grant_found && rst_n) begin
            req_ready[grant_idx] = 1'b1;
        end
        if (state == S_RESP) begin
            rsp_valid[last_grant] = 1'b1;
        end
    end

    // ALU-driving registers, hold counter, grant history and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant   <= GW'(NUM_REQ - 1);
            hold_cnt     <= '0;
            alu_op       <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            rsp_data     <= '0;
            rsp_div_zero <= 1'b0;
        end else begin
            if (accept) begin
                alu_op     <= sel_op;
                alu_a      <= sel_a;
                alu_b      <= sel_b;
                last_grant <= grant_idx;
                hold_cnt   <= sel_long ? CW'(MULDIV_CYCLES - 1) : '0;
            end else if (((state == S_EXEC) || (state == S_WAIT)) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
            if (capture) begin
                if ((alu_op == OP_DIV) && (alu_b == '0)) begin
                    rsp_data     <= '1;
                    rsp_div_zero <= 1'b1;
                end else begin
                    rsp_data     <= alu_f;
                    rsp_div_zero <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a multicycle ALU model
module tb_alu_arbiter;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int MD = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [3*N-1:0]  req_op = '0;
    logic [DW*N-1:0] req_a = '0;
    logic [DW*N-1:0] req_b = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_div_zero;
    logic            busy;
    logic [2:0]      alu_op;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [DW-1:0]   alu_f;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MULDIV_CYCLES(MD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_div_zero(rsp_div_zero), .busy(busy),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Multicycle ALU: mul/div only produce a real answer once inputs have been stable MD cycles
    logic [2*DW+2:0] cur_in;
    logic [2*DW+2:0] last_in = '0;
    int              age_reg = 0;
    int              age;
    logic [2*DW-1:0] prod;
    assign cur_in = {alu_op, alu_a, alu_b};

    always @(posedge clk) begin
        age_reg <= (cur_in == last_in) ? age_reg + 1 : 1;
        last_in <= cur_in;
    end

    always_comb begin
        age   = (cur_in == last_in) ? age_reg : 0;
        prod  = alu_a * alu_b;
        alu_f = '0;
        case (alu_op)
            3'd0: alu_f = alu_a + alu_b;
            3'd1: alu_f = alu_a - alu_b;
            3'd2: alu_f = (age >= MD - 1) ? prod[DW-1:0] : 16'hDEAD;
            3'd3: alu_f = (alu_b == '0) ? 16'h0000 : ((age >= MD - 1) ? alu_a / alu_b : 16'hDEAD);
            3'd4: alu_f = ~alu_a;
            3'd5: alu_f = alu_a ^ alu_b;
            3'd6: alu_f = alu_a | alu_b;
            default: alu_f = alu_a & alu_b;
        endcase
    end

    // Reference arithmetic for the value the requester should receive
    function automatic logic [DW-1:0] ref_res(input logic [2:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        int unsigned ua;
        int unsigned ub;
        ua = a;
        ub = b;
        case (op)
            3'd0: return DW'(ua + ub);
            3'd1: return DW'(ua - ub);
            3'd2: return DW'(ua * ub);
            3'd3: return (ub == 0) ? 16'hFFFF : DW'(ua / ub);
            3'd4: return ~a;
            3'd5: return a ^ b;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: cycle-level timeline of the single in-flight operation
    int            m_last = N - 1;
    int            m_idle = 0;
    int            acc_cycle = -100;
    int            acc_h = 0;
    int            pend_cycle = 0;
    int            pend_idx = 0;
    logic          pend_v = 1'b0;
    logic [DW-1:0] pend_data = '0;
    logic          pend_dz = 1'b0;
    logic [DW-1:0] held_data = '0;
    logic          held_dz = 1'b0;
    logic [2:0]    h_op = '0;
    logic [DW-1:0] h_a = '0;
    logic [DW-1:0] h_b = '0;
    logic [N-1:0]  acc_vec = '0;
    int            log_q[$];

    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rv;
        int w;
        if (!rst_n) begin
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_alu_op", 32'(alu_op), 32'd0);
            chk("rst_alu_a", 32'(alu_a), 32'd0);
            chk("rst_alu_b", 32'(alu_b), 32'd0);
            chk("rst_rsp_data", 32'(rsp_data), 32'd0);
            m_last    = N - 1;
            m_idle    = 0;
            pend_v    = 1'b0;
            held_data = '0;
            held_dz   = 1'b0;
            acc_vec   = '0;
            acc_cycle = -100;
        end else begin
            exp_rv = '0;
            if (pend_v && (cyc == pend_cycle)) exp_rv[pend_idx] = 1'b1;
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv != '0) begin
                held_data = pend_data;
                held_dz   = pend_dz;
                pend_v    = 1'b0;
            end
            chk("rsp_data", 32'(rsp_data), 32'(held_data));
            chk("rsp_div_zero", 32'(rsp_div_zero), 32'(held_dz));
            chk("busy", 32'(busy), 32'(cyc < m_idle));
            if ((cyc > acc_cycle) && (cyc <= acc_cycle + acc_h)) begin
                chk("hold_op", 32'(alu_op), 32'(h_op));
                chk("hold_a", 32'(alu_a), 32'(h_a));
                chk("hold_b", 32'(alu_b), 32'(h_b));
            end
            exp_ready = '0;
            acc_vec   = '0;
            w         = 0;
            if ((cyc >= m_idle) && (req_valid != '0)) begin
                for (int k = 1; k <= N; k++) begin
                    if ((exp_ready == '0) && req_valid[(m_last + k) % N]) begin
                        w = (m_last + k) % N;
                        exp_ready[w] = 1'b1;
                    end
                end
            end
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            if (exp_ready != '0) begin
                h_op       = req_op[3*w +: 3];
                h_a        = req_a[DW*w +: DW];
                h_b        = req_b[DW*w +: DW];
                acc_h      = ((h_op == 3'd2) || ((h_op == 3'd3) && (h_b != '0))) ? MD : 1;
                acc_cycle  = cyc;
                pend_v     = 1'b1;
                pend_idx   = w;
                pend_cycle = cyc + 1 + acc_h;
                pend_data  = ref_res(h_op, h_a, h_b);
                pend_dz    = (h_op == 3'd3) && (h_b == '0);
                m_idle     = cyc + 2 + acc_h;
                m_last     = w;
                acc_vec    = exp_ready;
                log_q.push_back(w);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_vec[i]) req_valid[i] = 1'b0;
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
        req_op[3*i +: 3] = op;
        req_a[DW*i +: DW] = a;
        req_b[DW*i +: DW] = b;
        req_valid[i] = 1'b1;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (((req_valid != '0) || (cyc < m_idle)) && (n < maxc)) begin
            step();
            n++;
        end
        if (n >= maxc) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int base;
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        set_req(0, 3'd0, 16'h1234, 16'h0001);
        drain(50);
        chk("t1_add", 32'(rsp_data), 32'h1235);

        set_req(1, 3'd2, 16'h0100, 16'h0100);
        drain(50);
        chk("t2_mul_wrap", 32'(rsp_data), 32'h0000);

        set_req(2, 3'd3, 16'h0007, 16'h0000);
        drain(50);
        chk("t3_div0_data", 32'(rsp_data), 32'hFFFF);
        chk("t3_div0_flag", 32'(rsp_div_zero), 32'd1);

        set_req(3, 3'd1, 16'h0000, 16'h0001);
        drain(50);
        chk("t6_sub_data", 32'(rsp_data), 32'hFFFF);
        chk("t6_sub_flag", 32'(rsp_div_zero), 32'd0);

        base = log_q.size();
        for (int i = 0; i < N; i++) set_req(i, 3'(i), 16'(i + 3), 16'(i + 1));
        n = 0;
        while ((log_q.size() < base + 5) && (n < 200)) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) set_req(i, 3'($urandom_range(7)), 16'($urandom), 16'($urandom));
            end
            n++;
        end
        req_valid = '0;
        drain(50);
        chk("t4_grant_count", 32'(log_q.size() - base), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (base + k < log_q.size()) chk("t4_order", 32'(log_q[base + k]), 32'(k % N));
        end

        set_req(0, 3'd3, 16'd100, 16'd7);
        n = 0;
        step();
        while (!acc_vec[0] && (n < 20)) begin
            step();
            n++;
        end
        chk("t5_accept_seen", 32'(acc_vec[0]), 32'd1);
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_alu_op", 32'(alu_op), 32'd0);
        chk("t5_alu_a", 32'(alu_a), 32'd0);
        chk("t5_alu_b", 32'(alu_b), 32'd0);
        chk("t5_req_ready", 32'(req_ready), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        base = log_q.size();
        set_req(2, 3'd5, 16'h00F0, 16'h0F0F);
        set_req(0, 3'd6, 16'h1000, 16'h0001);
        drain(100);
        chk("t5_grants", 32'(log_q.size() - base), 32'd2);
        if (log_q.size() > base) chk("t5_first_grant", 32'(log_q[base]), 32'd0);

        for (int t = 0; t < 1500; t++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(2) == 0) begin
                        set_req(i, 3'($urandom_range(7)), 16'($urandom),
                                ($urandom_range(7) == 0) ? 16'h0000 : 16'($urandom));
                    end
                end else if ($urandom_range(19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
